// File: rtl/analogue_capture_buffer_if.sv
// rtl/analogue_capture_buffer_if.sv - sample stream, capture control and readout bundle
interface analogue_capture_buffer_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ADDR_WIDTH   = 10
);
  logic                    sample_valid;
  logic [SAMPLE_WIDTH-1:0] sample;
  logic                    arm;
  logic [ADDR_WIDTH-1:0]   pre_samples;
  logic                    trigger;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [SAMPLE_WIDTH-1:0] rd_data;
  logic                    armed;
  logic                    busy;
  logic                    done;
  logic [ADDR_WIDTH-1:0]   trigger_index;

  modport master (
    output sample_valid, sample, arm, pre_samples, trigger, rd_addr,
    input  rd_data, armed, busy, done, trigger_index
  );

  modport slave (
    input  sample_valid, sample, arm, pre_samples, trigger, rd_addr,
    output rd_data, armed, busy, done, trigger_index
  );
endinterface

// File: rtl/analogue_capture_buffer.sv
// rtl/analogue_capture_buffer.sv - triggered circular acquisition memory with frozen readout
module analogue_capture_buffer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ADDR_WIDTH   = 10
) (
  input logic                      clk,
  input logic                      rst_n,
  analogue_capture_buffer_if.slave cap
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ARMED,
    S_POST,
    S_DONE
  } state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [ADDR_WIDTH-1:0]   start_ptr, start_next;
  logic [ADDR_WIDTH-1:0]   pre_q, pre_next;
  logic [ADDR_WIDTH-1:0]   tidx_q, tidx_next;
  logic [ADDR_WIDTH:0]     cnt, cnt_next;
  logic [ADDR_WIDTH:0]     cnt_inc;
  logic [ADDR_WIDTH:0]     post_target;
  logic                    pending, pending_next;
  logic                    wr_en;
  logic                    armed_q, busy_q, done_q;
  logic [SAMPLE_WIDTH-1:0] rd_data_q;
  logic [ADDR_WIDTH-1:0]   rd_phys;
  logic [SAMPLE_WIDTH-1:0] mem [DEPTH];

  // cnt counts pre-trigger samples in FILL and post-trigger samples (trigger included) in POST
  assign cnt_inc     = cnt + CNT_ONE;
  assign post_target = DEPTH_W - {1'b0, pre_q};
  assign rd_phys     = start_ptr + cap.rd_addr;

  // Next-state, write enable and capture bookkeeping; arm overrides everything, including trigger
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    pending_next = pending;
    pre_next     = pre_q;
    start_next   = start_ptr;
    tidx_next    = tidx_q;
    wr_en        = 1'b0;
    if (cap.arm) begin
      pre_next     = cap.pre_samples;
      cnt_next     = '0;
      pending_next = 1'b0;
      state_next   = (cap.pre_samples == '0) ? S_ARMED : S_FILL;
    end else begin
      case (state)
        S_FILL: begin
          if (cap.sample_valid) begin
            wr_en = 1'b1;
            if (cnt_inc == {1'b0, pre_q}) begin
              state_next = S_ARMED;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_inc;
            end
          end
        end
        S_ARMED: begin
          if (cap.sample_valid) begin
            wr_en = 1'b1;
            if (cap.trigger || pending) begin
              pending_next = 1'b0;
              if (post_target == CNT_ONE) begin
                state_next = S_DONE;
                start_next = wr_ptr + PTR_ONE;
                tidx_next  = pre_q;
              end else begin
                state_next = S_POST;
                cnt_next   = CNT_ONE;
              end
            end
          end else if (cap.trigger) begin
            pending_next = 1'b1;
          end
        end
        S_POST: begin
          if (cap.sample_valid) begin
            wr_en = 1'b1;
            if (cnt_inc == post_target) begin
              state_next = S_DONE;
              start_next = wr_ptr + PTR_ONE;
              tidx_next  = pre_q;
            end else begin
              cnt_next = cnt_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State, pointers and registered status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      start_ptr <= '0;
      pre_q     <= '0;
      tidx_q    <= '0;
      cnt       <= '0;
      pending   <= 1'b0;
      armed_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_next;
      start_ptr <= start_next;
      pre_q     <= pre_next;
      tidx_q    <= tidx_next;
      cnt       <= cnt_next;
      pending   <= pending_next;
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      armed_q <= (state_next == S_ARMED);
      busy_q  <= (state_next == S_FILL) || (state_next == S_ARMED) || (state_next == S_POST);
      done_q  <= (state_next == S_DONE);
    end
  end

  // Sample RAM write port; suppressed while reset is held
  always_ff @(posedge clk) begin
    if (wr_en && rst_n) begin
      mem[wr_ptr] <= cap.sample;
    end
  end

  // Registered read port, logical index rebased onto the oldest sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_phys];
    end
  end

  assign cap.rd_data       = rd_data_q;
  assign cap.armed         = armed_q;
  assign cap.busy          = busy_q;
  assign cap.done          = done_q;
  assign cap.trigger_index = tidx_q;

endmodule

// File: tb/tb_analogue_capture_buffer.sv
// tb/tb_analogue_capture_buffer.sv - scoreboard bench for analogue_capture_buffer
module tb_analogue_capture_buffer;

  localparam int SW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  analogue_capture_buffer_if #(.SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW)) cap_if ();

  analogue_capture_buffer #(.SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cap   (cap_if)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [SW-1:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cap_if.sample_valid = 1'b0;
    cap_if.sample       = '0;
    cap_if.arm          = 1'b0;
    cap_if.pre_samples  = '0;
    cap_if.trigger      = 1'b0;
    cap_if.rd_addr      = '0;
  endtask

  // Arms a capture and streams running-count samples until done (or stop_after cycles)
  task automatic do_capture(input int pre, input int period, input int trig_n,
                            input bit trig_early, input bit fill_trig,
                            input bit arm_trig, input bit arm_valid,
                            input int stop_after, input string tag);
    int cnt;
    int cyc;
    bit valid;
    bit got_done;
    logic [2:0] exp_flags;
    cap_if.arm          = 1'b1;
    cap_if.pre_samples  = pre[AW-1:0];
    cap_if.trigger      = arm_trig;
    cap_if.sample_valid = arm_valid;
    cap_if.sample       = 16'hBEEF;
    tick();
    cap_if.arm          = 1'b0;
    cap_if.trigger      = 1'b0;
    cap_if.sample_valid = 1'b0;
    exp_flags = {(pre == 0), 1'b1, 1'b0};
    n_total++;
    if ({cap_if.armed, cap_if.busy, cap_if.done} !== exp_flags)
      $display("FAIL %s_arm_flags: got %b expected %b", tag,
               {cap_if.armed, cap_if.busy, cap_if.done}, exp_flags);
    else
      n_pass++;
    cnt = 0;
    cyc = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 1000 && !(stop_after > 0 && cyc >= stop_after)) begin
      valid = (cyc % period == 0);
      cap_if.sample_valid = valid;
      cap_if.sample       = cnt[SW-1:0];
      if (trig_early)
        cap_if.trigger = (cyc % period == period - 1) && (cnt == trig_n);
      else
        cap_if.trigger = valid && (cnt == trig_n);
      if (fill_trig && valid && cnt == 1)
        cap_if.trigger = 1'b1;
      tick();
      if (trig_early && cap_if.trigger && !valid) begin
        n_total++;
        if ({cap_if.armed, cap_if.busy, cap_if.done} !== 3'b110)
          $display("FAIL %s_pending_flags: got %b expected 110", tag,
                   {cap_if.armed, cap_if.busy, cap_if.done});
        else
          n_pass++;
      end
      if (valid) cnt++;
      cyc++;
      got_done = cap_if.done;
    end
    cap_if.sample_valid = 1'b0;
    cap_if.trigger      = 1'b0;
    if (stop_after == 0 && !got_done) begin
      n_total++;
      $display("FAIL %s_timeout: got done=0 after %0d cycles expected done=1", tag, cyc);
    end
  endtask

  // Reads the frozen record through the scoreboard; expected value at index i is first+i
  task automatic read_record(input int first, input int pre, input bit check_lag, input string tag);
    logic [SW-1:0] e;
    n_total++;
    if ({cap_if.armed, cap_if.busy, cap_if.done} !== 3'b001)
      $display("FAIL %s_done_flags: got %b expected 001", tag,
               {cap_if.armed, cap_if.busy, cap_if.done});
    else
      n_pass++;
    n_total++;
    if (cap_if.trigger_index !== pre[AW-1:0])
      $display("FAIL %s_trigger_index: got %0d expected %0d", tag, cap_if.trigger_index, pre);
    else
      n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      cap_if.rd_addr = i[AW-1:0];
      exp_q.push_back(SW'(first + i));
      if (check_lag && i > 0) begin
        #1;
        n_total++;
        if (cap_if.rd_data !== SW'(first + i - 1))
          $display("FAIL %s_lag_%0d: got %0d expected %0d", tag, i, cap_if.rd_data, first + i - 1);
        else
          n_pass++;
      end
      tick();
      e = exp_q.pop_front();
      n_total++;
      if (cap_if.rd_data !== e)
        $display("FAIL %s_rd_%0d: got %0d expected %0d", tag, i, cap_if.rd_data, e);
      else
        n_pass++;
    end
    cap_if.rd_addr = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    n_total++;
    if ({cap_if.armed, cap_if.busy, cap_if.done, cap_if.rd_data, cap_if.trigger_index} !== '0)
      $display("FAIL reset_outputs: got a=%b b=%b d=%b rd=%0d ti=%0d expected all 0",
               cap_if.armed, cap_if.busy, cap_if.done, cap_if.rd_data, cap_if.trigger_index);
    else
      n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    do_capture(4, 1, 9, 1'b0, 1'b0, 1'b0, 1'b0, 0, "basic");
    read_record(5, 4, 1'b0, "basic");
  endtask

  task automatic test_pre_zero();
    do_capture(0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "pre0");
    read_record(0, 0, 1'b0, "pre0");
  endtask

  task automatic test_trig_between();
    do_capture(4, 3, 6, 1'b1, 1'b1, 1'b0, 1'b0, 0, "between");
    read_record(2, 4, 1'b0, "between");
  endtask

  task automatic test_wrap();
    do_capture(8, 1, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0, "wrap_a");
    read_record(0, 8, 1'b1, "wrap_a");
    do_capture(8, 1, 13, 1'b0, 1'b0, 1'b0, 1'b0, 0, "wrap_b");
    read_record(5, 8, 1'b1, "wrap_b");
    do_capture(8, 1, 10, 1'b0, 1'b0, 1'b0, 1'b1, 0, "wrap_c");
    read_record(2, 8, 1'b1, "wrap_c");
  endtask

  task automatic test_reset_mid_post();
    do_capture(4, 1, 5, 1'b0, 1'b0, 1'b0, 1'b0, 9, "rstpost");
    n_total++;
    if ({cap_if.armed, cap_if.busy, cap_if.done} !== 3'b010)
      $display("FAIL rstpost_in_post: got %b expected 010", {cap_if.armed, cap_if.busy, cap_if.done});
    else
      n_pass++;
    rst_n = 1'b0;
    tick();
    tick();
    n_total++;
    if ({cap_if.armed, cap_if.busy, cap_if.done, cap_if.rd_data, cap_if.trigger_index} !== '0)
      $display("FAIL rstpost_outputs: got a=%b b=%b d=%b rd=%0d ti=%0d expected all 0",
               cap_if.armed, cap_if.busy, cap_if.done, cap_if.rd_data, cap_if.trigger_index);
    else
      n_pass++;
    rst_n = 1'b1;
    tick();
    do_capture(2, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0, "rstpost_re");
    read_record(1, 2, 1'b0, "rstpost_re");
  endtask

  task automatic test_abort();
    do_capture(4, 1, 6, 1'b0, 1'b0, 1'b0, 1'b0, 10, "abort");
    n_total++;
    if ({cap_if.armed, cap_if.busy, cap_if.done} !== 3'b010)
      $display("FAIL abort_in_post: got %b expected 010", {cap_if.armed, cap_if.busy, cap_if.done});
    else
      n_pass++;
    do_capture(0, 1, 5, 1'b0, 1'b0, 1'b1, 1'b1, 0, "abort_re");
    read_record(5, 0, 1'b0, "abort_re");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pre_zero();
    test_trig_between();
    test_wrap();
    test_reset_mid_post();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
